// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped input port.
// Used by the input port itself, the core and the address decoder so they
// all agree on where the register window lives and how it is laid out.
//   REG_*              word offsets of the registers inside the window
//   MMIO_WINDOW        number of words the peripheral claims
//   DEFAULT_BASE_ADDR  word address of register 0 in the default build
package mmio_pkg;

    localparam logic [1:0] REG_STATE = 2'd0;
    localparam logic [1:0] REG_EDGE  = 2'd1;
    localparam logic [1:0] REG_MASK  = 2'd2;
    localparam logic [1:0] REG_FEDGE = 2'd3;

    localparam int unsigned MMIO_WINDOW = 4;

    localparam logic [9:0] DEFAULT_BASE_ADDR = 10'h3F0;

endpackage

// File: rtl/mmio_input_port_if.sv
// Data-bus bundle between the pipelined core and a memory-mapped peripheral.
//   daddr     word address from the core
//   mem_read  load strobe
//   mem_write store strobe
//   ddata_w   store data
//   ddata_r   registered load data, zero when the peripheral is not answering
// The master modport is the core side, the slave modport the peripheral side.
interface mmio_input_port_if #(
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned DATA_SIZE = 32
);

    logic [ADDR_SIZE-1:0] daddr;
    logic                 mem_read;
    logic                 mem_write;
    logic [DATA_SIZE-1:0] ddata_w;
    logic [DATA_SIZE-1:0] ddata_r;

    modport master (
        output daddr,
        output mem_read,
        output mem_write,
        output ddata_w,
        input  ddata_r
    );

    modport slave (
        input  daddr,
        input  mem_read,
        input  mem_write,
        input  ddata_w,
        output ddata_r
    );

endinterface

// File: rtl/input_debouncer.sv
// One-bit input conditioner: two-flop synchroniser followed by a debounce
// counter that only accepts a new level after it has been seen for
// DEBOUNCE_CYCLES consecutive cycles.
//   clk, rst      clock and asynchronous active-high reset
//   raw_in        raw asynchronous input
//   state_o       debounced level
//   state_next_o  level the debounced flop will take at the next edge,
//                 so the parent can detect transitions in the same cycle
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic state_o,
    output logic state_next_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreeing cycle throws the partial count away, so a
    // glitch shorter than DEBOUNCE_CYCLES never reaches state_q.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = '0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o      = state_q;
    assign state_next_o = state_d;

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped input peripheral: debounced switches/buttons, sticky
// rising-edge flags and a maskable level interrupt.
//   CLK, RESET  clock and asynchronous active-high reset
//   bus         data-bus slave (daddr, mem_read, mem_write, ddata_w, ddata_r)
//   SW          raw asynchronous inputs
//   irq         registered interrupt, |(EDGE & MASK)
// Register window (word offsets from BASE_ADDR):
//   +0 STATE (RO), +1 EDGE (W1C), +2 MASK (RW), +3 FEDGE (W1C) or reserved.
// Build option FALLING_EDGE_CAPTURE_EN adds the FEDGE register and lets it
// contribute to irq; without it +3 reads zero and ignores writes.
// Loads answer one cycle later with zero otherwise, matching the data RAM so
// the two read buses can simply be OR-ed together.
module mmio_input_port
    import mmio_pkg::*;
#(
    parameter int unsigned          ADDR_SIZE       = 10,
    parameter int unsigned          DATA_SIZE       = 32,
    parameter int unsigned          NUM_IN          = 8,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR       = ADDR_SIZE'(DEFAULT_BASE_ADDR),
    parameter int unsigned          DEBOUNCE_CYCLES = 500000
) (
    input  logic                CLK,
    input  logic                RESET,
    mmio_input_port_if.slave    bus,
    input  logic [NUM_IN-1:0]   SW,
    output logic                irq
);

    logic [NUM_IN-1:0]    state;
    logic [NUM_IN-1:0]    state_next;
    logic [NUM_IN-1:0]    rise;
    logic [NUM_IN-1:0]    edge_q, edge_d;
    logic [NUM_IN-1:0]    mask_q, mask_d;
    logic [NUM_IN-1:0]    wr_bits;
    logic [DATA_SIZE-1:0] ddata_r_q, ddata_r_d;
    logic [DATA_SIZE-1:0] rd_val;
    logic                 irq_q, irq_d;
    logic [ADDR_SIZE:0]   addr_ext, base_ext, limit_ext;
    logic                 sel, rd_en, wr_en;
    logic [1:0]           offset;
    logic                 unused_wdata;
`ifdef FALLING_EDGE_CAPTURE_EN
    logic [NUM_IN-1:0]    fall;
    logic [NUM_IN-1:0]    fedge_q, fedge_d;
`endif

    for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk          (CLK),
            .rst          (RESET),
            .raw_in       (SW[i]),
            .state_o      (state[i]),
            .state_next_o (state_next[i])
        );
    end

    // Transitions are taken from the debouncer's next level so the flags set
    // on the same edge that STATE changes.
    assign rise = state_next & ~state;
`ifdef FALLING_EDGE_CAPTURE_EN
    assign fall = ~state_next & state;
`endif

    // Decode is done one bit wider so a window at the very top of the
    // address space cannot wrap around to zero.
    assign addr_ext  = {1'b0, bus.daddr};
    assign base_ext  = {1'b0, BASE_ADDR};
    assign limit_ext = base_ext + (ADDR_SIZE + 1)'(MMIO_WINDOW);
    assign sel       = (addr_ext >= base_ext) && (addr_ext < limit_ext);
    assign offset    = bus.daddr[1:0] - BASE_ADDR[1:0];
    assign rd_en     = bus.mem_read && sel;
    assign wr_en     = bus.mem_write && sel;

    // Only the low NUM_IN store bits land anywhere.
    assign unused_wdata = ^bus.ddata_w;

    // Read mux, register updates and interrupt. Reads always see the
    // pre-write values because everything here uses the _q side; on EDGE the
    // clear is applied before the new rising edges are OR-ed in so a set in
    // the same cycle wins.
    always_comb begin
        rd_val = '0;
        case (offset)
            REG_STATE: rd_val = DATA_SIZE'(state);
            REG_EDGE:  rd_val = DATA_SIZE'(edge_q);
            REG_MASK:  rd_val = DATA_SIZE'(mask_q);
`ifdef FALLING_EDGE_CAPTURE_EN
            REG_FEDGE: rd_val = DATA_SIZE'(fedge_q);
`endif
            default:   rd_val = '0;
        endcase

        wr_bits   = bus.ddata_w[NUM_IN-1:0];
        ddata_r_d = rd_en ? rd_val : '0;

        edge_d = edge_q;
        if (wr_en && (offset == REG_EDGE)) begin
            edge_d = edge_q & ~wr_bits;
        end
        edge_d = edge_d | rise;

        mask_d = mask_q;
        if (wr_en && (offset == REG_MASK)) begin
            mask_d = wr_bits;
        end

`ifdef FALLING_EDGE_CAPTURE_EN
        fedge_d = fedge_q;
        if (wr_en && (offset == REG_FEDGE)) begin
            fedge_d = fedge_q & ~wr_bits;
        end
        fedge_d = fedge_d | fall;
        irq_d   = |((edge_q | fedge_q) & mask_q);
`else
        irq_d   = |(edge_q & mask_q);
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            edge_q    <= '0;
            mask_q    <= '0;
            ddata_r_q <= '0;
            irq_q     <= 1'b0;
`ifdef FALLING_EDGE_CAPTURE_EN
            fedge_q   <= '0;
`endif
        end else begin
            edge_q    <= edge_d;
            mask_q    <= mask_d;
            ddata_r_q <= ddata_r_d;
            irq_q     <= irq_d;
`ifdef FALLING_EDGE_CAPTURE_EN
            fedge_q   <= fedge_d;
`endif
        end
    end

    assign bus.ddata_r = ddata_r_q;
    assign irq         = irq_q;

endmodule
